// File: rtl/enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : enemy_fire_scheduler
// Brief    : Rate-timed, LFSR-seeded pick of a living enemy; issues a one-hot
//            fire pulse and caps the number of enemy shots in flight.
//            Optional statistics outputs when ENEMY_FIRE_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_fire_scheduler #(
    parameter int          N_ENEMY   = 24,
    parameter int          DELAY     = 100000,
    parameter int          MAX_SHOTS = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [N_ENEMY-1:0]                 enemy_vivos,
    input  logic                               shot_done,
    output logic [N_ENEMY-1:0]                 ID_enemy_tiro,
    output logic                               fire_valid,
    output logic [$clog2(N_ENEMY)-1:0]         fire_idx,
    output logic [$clog2(MAX_SHOTS+1)-1:0]     shots_active,
    output logic                               busy
`ifdef ENEMY_FIRE_STATS_EN
    ,
    output logic [15:0]                        shots_fired,
    output logic [$clog2(N_ENEMY+1)-1:0]       scan_max
`endif
);

    localparam int c_IDX_W = $clog2(N_ENEMY);
    localparam int c_CNT_W = $clog2(N_ENEMY+1);
    localparam int c_SA_W  = $clog2(MAX_SHOTS+1);
    localparam int c_TMR_W = $clog2(DELAY);

    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(DELAY-1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_ENEMY-1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(N_ENEMY);
    localparam logic [c_SA_W-1:0]  c_SA_MAX   = c_SA_W'(MAX_SHOTS);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_PICK = 2'd1,
        S_SCAN = 2'd2,
        S_FIRE = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_TMR_W-1:0]   r_timer, w_timer_nxt;
    logic [15:0]          r_lfsr, w_lfsr_nxt;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nxt, w_pick_idx;
    logic [c_CNT_W-1:0]   r_scan_cnt, w_scan_cnt_nxt, w_scan_inc;
    logic [c_SA_W-1:0]    r_shots, w_shots_nxt;
    logic [N_ENEMY-1:0]   r_id, w_id_nxt;
    logic                 r_fire_v, w_fire_v_nxt;
    logic [c_IDX_W-1:0]   r_fire_idx, w_fire_idx_nxt;
    logic                 w_fire;

    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_pick_idx = c_IDX_W'(32'(r_lfsr[7:0]) % N_ENEMY);
    assign w_scan_inc = r_scan_cnt + 1'b1;
    assign w_fire     = (r_state == S_FIRE);

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_idx_nxt      = r_idx;
        w_scan_cnt_nxt = r_scan_cnt;
        w_id_nxt       = '0;
        w_fire_v_nxt   = 1'b0;
        w_fire_idx_nxt = '0;
        case (r_state)
            S_WAIT: begin
                // Timer parks at its last value until a shot may be issued
                if (r_timer == c_TMR_LAST) begin
                    if (enable && (r_shots < c_SA_MAX) && (|enemy_vivos))
                        w_state_nxt = S_PICK;
                end else if (enable) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_PICK: begin
                if (!enable) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_idx_nxt      = w_pick_idx;
                    w_scan_cnt_nxt = '0;
                    w_state_nxt    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!enable) begin
                    w_state_nxt = S_WAIT;
                end else if (enemy_vivos[r_idx]) begin
                    w_state_nxt    = S_FIRE;
                    w_id_nxt       = N_ENEMY'(1) << r_idx;
                    w_fire_v_nxt   = 1'b1;
                    w_fire_idx_nxt = r_idx;
                end else begin
                    w_idx_nxt      = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                    w_scan_cnt_nxt = w_scan_inc;
                    // Every slot probed dead: give up this attempt
                    if (w_scan_inc == c_CNT_FULL) begin
                        w_state_nxt = S_WAIT;
                        w_timer_nxt = '0;
                    end
                end
            end
            S_FIRE: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        w_shots_nxt = r_shots;
        if (w_fire && !shot_done)
            w_shots_nxt = r_shots + 1'b1;
        else if (!w_fire && shot_done && (r_shots != '0))
            w_shots_nxt = r_shots - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_WAIT;
            r_timer    <= '0;
            r_lfsr     <= LFSR_SEED;
            r_idx      <= '0;
            r_scan_cnt <= '0;
            r_shots    <= '0;
            r_id       <= '0;
            r_fire_v   <= 1'b0;
            r_fire_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_idx      <= w_idx_nxt;
            r_scan_cnt <= w_scan_cnt_nxt;
            r_shots    <= w_shots_nxt;
            r_id       <= w_id_nxt;
            r_fire_v   <= w_fire_v_nxt;
            r_fire_idx <= w_fire_idx_nxt;
        end
    end

    assign ID_enemy_tiro = r_id;
    assign fire_valid    = r_fire_v;
    assign fire_idx      = r_fire_idx;
    assign shots_active  = r_shots;
    assign busy          = (r_state == S_PICK) || (r_state == S_SCAN);

`ifdef ENEMY_FIRE_STATS_EN
    logic [15:0]        r_shots_fired;
    logic [c_CNT_W-1:0] r_scan_max;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shots_fired <= '0;
            r_scan_max    <= '0;
        end else begin
            if (w_fire && (r_shots_fired != 16'hFFFF))
                r_shots_fired <= r_shots_fired + 1'b1;
            // A scan completes on a hit or on exhaustion; aborts do not count
            if ((r_state == S_SCAN) && enable) begin
                if (enemy_vivos[r_idx]) begin
                    if (r_scan_cnt > r_scan_max)
                        r_scan_max <= r_scan_cnt;
                end else if (w_scan_inc == c_CNT_FULL) begin
                    r_scan_max <= c_CNT_FULL;
                end
            end
        end
    end

    assign shots_fired = r_shots_fired;
    assign scan_max    = r_scan_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_fire_scheduler
// Brief    : Directed self-checking bench for enemy_fire_scheduler (DELAY=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_fire_scheduler;

    localparam int          c_N    = 24;
    localparam int          c_DLY  = 8;
    localparam int          c_MS   = 2;
    localparam logic [15:0] c_SEED = 16'hACE1;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [c_N-1:0]  vivos;
    logic            shot_done;
    logic [c_N-1:0]  id;
    logic            fire_valid;
    logic [4:0]      fire_idx;
    logic [1:0]      shots;
    logic            busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    enemy_fire_scheduler #(
        .N_ENEMY   (c_N),
        .DELAY     (c_DLY),
        .MAX_SHOTS (c_MS),
        .LFSR_SEED (c_SEED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .enemy_vivos   (vivos),
        .shot_done     (shot_done),
        .ID_enemy_tiro (id),
        .fire_valid    (fire_valid),
        .fire_idx      (fire_idx),
        .shots_active  (shots),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR steps on every edge, reloading the seed while reset is low
    task automatic tick;
        @(posedge clk);
        m_lfsr = reset ? {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]}
                       : c_SEED;
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick;
            chk("wait_nofire", 32'(fire_valid), 32'd0);
        end
    endtask

    task automatic pulse_done(input int exp_shots);
        shot_done = 1'b1;
        tick;
        shot_done = 1'b0;
        chk("shots_after_done", 32'(shots), 32'(exp_shots));
    endtask

    // Timer is at DELAY-1: PICK, probe until the first living enemy, FIRE, back to WAIT
    task automatic pick_fire(input int exp_shots, input bit sd_at_fire);
        int         cand;
        int         skip;
        logic [4:0] e_idx;
        tick;
        chk("pick_busy", 32'(busy), 32'd1);
        cand = int'(m_lfsr[7:0]) % c_N;
        skip = 0;
        while (skip < c_N && !vivos[(cand + skip) % c_N]) skip++;
        e_idx = 5'((cand + skip) % c_N);
        for (int d = 0; d <= skip; d++) begin
            tick;
            chk("scan_nofire", 32'(fire_valid), 32'd0);
            chk("scan_busy", 32'(busy), 32'd1);
        end
        tick;
        chk("fire_valid", 32'(fire_valid), 32'd1);
        chk("fire_idx", 32'(fire_idx), 32'(e_idx));
        chk("fire_onehot", 32'(id), 32'(24'(1) << e_idx));
        chk("fire_busy", 32'(busy), 32'd0);
        if (sd_at_fire) shot_done = 1'b1;
        tick;
        shot_done = 1'b0;
        chk("fire_clear", 32'(fire_valid), 32'd0);
        chk("fire_id_clear", 32'(id), 32'd0);
        chk("shots_after_fire", 32'(shots), 32'(exp_shots));
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        shot_done = 1'b0;
        vivos     = '1;
        repeat (3) tick;
        chk("rst_fire_valid", 32'(fire_valid), 32'd0);
        chk("rst_id", 32'(id), 32'd0);
        chk("rst_fire_idx", 32'(fire_idx), 32'd0);
        chk("rst_shots", 32'(shots), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lfsr", 32'(dut.r_lfsr), 32'h0000ACE1);
        chk("rst_timer", 32'(dut.r_timer), 32'd0);

        // All alive, slot released after every fire: one fire per 11 cycles
        reset  = 1'b1;
        enable = 1'b1;
        for (int p = 0; p < 3; p++) begin
            pulse_done(0);
            wait_ticks(6);
            pick_fire(1, 1'b0);
        end

        // Only enemy 17 alive; no releases, so the cap fills up
        vivos = 24'h020000;
        pulse_done(0);
        wait_ticks(6);
        pick_fire(1, 1'b0);
        wait_ticks(7);
        pick_fire(2, 1'b0);

        // At the cap: timer parks at DELAY-1, nothing fires
        vivos = '1;
        wait_ticks(27);
        chk("cap_timer", 32'(dut.r_timer), 32'(c_DLY - 1));
        chk("cap_shots", 32'(shots), 32'd2);
        chk("cap_busy", 32'(busy), 32'd0);
        pulse_done(1);
        pick_fire(2, 1'b0);

        // Release coincident with FIRE leaves the count unchanged
        pulse_done(1);
        wait_ticks(6);
        pick_fire(1, 1'b1);

        // Every enemy dies during SCAN: full sweep, back to WAIT without firing
        wait_ticks(7);
        tick;
        chk("vanish_pick_busy", 32'(busy), 32'd1);
        tick;
        vivos = '0;
        for (int i = 0; i < c_N; i++) begin
            tick;
            chk("vanish_nofire", 32'(fire_valid), 32'd0);
        end
        chk("vanish_busy", 32'(busy), 32'd0);
        chk("vanish_timer", 32'(dut.r_timer), 32'd0);
        chk("vanish_shots", 32'(shots), 32'd1);

        // Reset in the middle of SCAN
        vivos = '1;
        wait_ticks(7);
        tick;
        tick;
        chk("midscan_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_fire_valid", 32'(fire_valid), 32'd0);
        chk("mrst_id", 32'(id), 32'd0);
        chk("mrst_fire_idx", 32'(fire_idx), 32'd0);
        chk("mrst_shots", 32'(shots), 32'd0);
        chk("mrst_lfsr", 32'(dut.r_lfsr), 32'h0000ACE1);
        chk("mrst_timer", 32'(dut.r_timer), 32'd0);

        // Frozen game: timer holds, LFSR keeps running
        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick;
            chk("frozen_nofire", 32'(fire_valid), 32'd0);
        end
        chk("frozen_timer", 32'(dut.r_timer), 32'd0);
        chk("frozen_busy", 32'(busy), 32'd0);
        chk("frozen_lfsr", 32'(dut.r_lfsr), 32'(m_lfsr));
        enable = 1'b1;
        wait_ticks(7);
        pick_fire(1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/enemy_fire_scheduler.md
Name: enemy_fire_scheduler

Overview:
- Decides when an enemy fires and which living enemy fires, then issues a one-hot fire pulse to the enemy shot datapath.
- Rate timer plus a free-running 16-bit LFSR pick a candidate; a bounded linear scan skips dead enemies.
- Caps the number of enemy shots in flight; the shot datapath releases slots via shot_done.
- Sits between the game engine (game-running status, enemy alive mask) and the enemy projectile logic.

Parameters:
N_ENEMY, 24, number of enemies; alive-mask and one-hot output width.
DELAY, 100000, WAIT cycles between fire attempts; DELAY >= 2.
MAX_SHOTS, 2, maximum concurrent enemy shots; >= 1.
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  1 = game running; 0 = scheduling frozen
enemy_vivos  in  N_ENEMY  alive mask, bit i = enemy i alive
shot_done  in  1  1-cycle pulse: one enemy shot ended (hit or off-screen)
ID_enemy_tiro  out  N_ENEMY  one-hot fire pulse, 1 cycle
fire_valid  out  1  high in the same cycle as ID_enemy_tiro
fire_idx  out  $clog2(N_ENEMY)  index of the firing enemy; valid with fire_valid
shots_active  out  $clog2(MAX_SHOTS+1)  shots currently in flight
busy  out  1  state is PICK or SCAN

Behaviour:
- Reset (reset==0 at a clk edge):
  - state = WAIT; timer = 0; lfsr = LFSR_SEED.
  - idx = 0; scan_cnt = 0; shots_active = 0.
  - ID_enemy_tiro = 0; fire_valid = 0; fire_idx = 0; busy = 0.
  - Reset wins over every other event, including mid-SCAN.
- LFSR:
  - 16-bit Fibonacci; next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances every cycle out of reset, regardless of enable.
- WAIT:
  - If enable, timer increments; otherwise timer holds.
  - At timer == DELAY-1 the block moves to PICK only if enable && (shots_active < MAX_SHOTS) && (|enemy_vivos).
  - Otherwise timer saturates at DELAY-1 until those conditions hold.
- PICK (1 cycle):
  - idx = lfsr[7:0] % N_ENEMY; scan_cnt = 0; go to SCAN.
- SCAN (1 cycle per probe):
  - If enemy_vivos[idx], go to FIRE.
  - Else idx = (idx == N_ENEMY-1) ? 0 : idx+1; scan_cnt++.
  - If scan_cnt reaches N_ENEMY (all enemies died mid-scan), go to WAIT with timer = 0 and no fire.
- FIRE (1 cycle):
  - Registered outputs: ID_enemy_tiro = 1 << idx; fire_valid = 1; fire_idx = idx.
  - shots_active increments; timer = 0; go to WAIT.
  - All three fire outputs are 0 in every other state.
- Latency: timer reaches DELAY-1 in cycle t → PICK at t+1 → first SCAN probe at t+2 → fire pulse at t+3 + (number of dead enemies skipped).
- enable low while in PICK or SCAN: abort to WAIT with timer held at DELAY-1, no fire. FIRE always completes.
- shots_active:
  - +1 on FIRE, -1 on shot_done.
  - Simultaneous FIRE and shot_done: unchanged.
  - shot_done at 0: ignored, stays 0.
  - Never exceeds MAX_SHOTS, because FIRE is reachable only when below the cap.
- enemy_vivos is sampled live each SCAN cycle; it is not latched.

Optional Feature:
- Macro: ENEMY_FIRE_STATS_EN.
- Defined:
  - Extra output shots_fired [15:0]: count of FIRE cycles, saturating at 16'hFFFF, reset to 0.
  - Extra output scan_max [$clog2(N_ENEMY+1)-1:0]: largest scan_cnt reached in any completed SCAN, reset to 0.
- Not defined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- DELAY=8, all 24 alive, shot_done pulsed after each fire → exactly one fire_valid per 11-cycle period (8 WAIT + PICK + SCAN + FIRE); ID_enemy_tiro one-hot and equal to 1<<fire_idx; fire_idx matches a reference LFSR model.
- Only enemy 17 alive (enemy_vivos=24'h020000) → every fire has fire_idx=17 and ID_enemy_tiro=24'h020000; scan wraps 23→0 when the candidate is >17.
- MAX_SHOTS=2, no shot_done → two fires, then shots_active=2, timer holds at DELAY-1, no further fire; one shot_done pulse → shots_active=1 and a fire 3 cycles later.
- enemy_vivos driven to 0 during SCAN → return to WAIT, fire_valid never asserted, timer=0, shots_active unchanged.
- shot_done coincident with FIRE at shots_active=1 → stays 1; shot_done at 0 → stays 0.
- reset=0 asserted mid-SCAN → next cycle: state WAIT, all outputs 0, lfsr=16'hACE1; enable=0 for 50 cycles → no fire and timer frozen.
